// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands a shared byte transmitter to NREQ requesters, one frame at a time.
// Optional build macro UART_ARB_HDR_EN prefixes every frame with header byte 8'hA0 | winner index.
//
// state | meaning
// IDLE  | no owner; search for next requester after ptr
// LOAD  | present shadow byte[idx] on tx_data, pulse tx_go
// WAIT  | wait for tx_done from the byte transmitter (no timeout)
// DONE  | pulse ack to owner, move ptr to owner, release grant
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int MAXB = 5
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*MAXB*8-1:0]   req_data,
    input  logic [NREQ*3-1:0]        req_len,
    output logic [7:0]               tx_data,
    output logic                     tx_go,
    input  logic                     tx_done,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          ack,
    output logic                     busy
);

    localparam int IW = $clog2(MAXB + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          ptr;
    logic [2:0]          gidx;
    logic [2:0]          win;
    logic                found;
    logic [2:0]          win_len;
    logic [IW-1:0]       win_total;
    logic [MAXB*8-1:0]   shadow;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_inc;
    logic [IW-1:0]       total;
    logic [7:0]          byte_cur;
    logic [7:0]          tx_hold;

    assign idx_inc = idx + 1'b1;

    // First requester strictly after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = 3'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        win_len = req_len[int'(win)*3 +: 3];
        if (int'(win_len) > MAXB) begin
            win_total = IW'(MAXB);
        end else begin
            win_total = IW'(win_len);
        end
`ifdef UART_ARB_HDR_EN
        win_total = win_total + 1'b1;
`endif
    end

    always_comb begin
`ifdef UART_ARB_HDR_EN
        if (idx == '0) begin
            byte_cur = 8'hA0 | {5'b00000, gidx};
        end else begin
            byte_cur = shadow[(int'(idx) - 1)*8 +: 8];
        end
`else
        byte_cur = shadow[int'(idx)*8 +: 8];
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = (win_total == '0) ? DONE : LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_nxt = (idx_inc == total) ? DONE : LOAD;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 3'(NREQ - 1);
            gidx    <= '0;
            grant   <= '0;
            shadow  <= '0;
            idx     <= '0;
            total   <= '0;
            tx_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_hold <= '0;
                    if (found) begin
                        gidx   <= win;
                        grant  <= NREQ'(1) << win;
                        shadow <= req_data[int'(win)*MAXB*8 +: MAXB*8];
                        total  <= win_total;
                        idx    <= '0;
                    end
                end
                LOAD: tx_hold <= byte_cur;
                WAIT: begin
                    if (tx_done) begin
                        idx <= idx_inc;
                    end
                end
                DONE: begin
                    ptr   <= gidx;
                    grant <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_go   = 1'b0;
        busy    = 1'b1;
        ack     = '0;
        tx_data = tx_hold;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                tx_data = 8'h00;
            end
            LOAD: begin
                tx_go   = 1'b1;
                tx_data = byte_cur;
            end
            DONE: ack = grant;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frames plus random traffic against a frame-level model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 5;
    localparam int DW   = MAXB * 8;

    logic                   sys_clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*DW-1:0]     req_data;
    logic [NREQ*3-1:0]      req_len;
    logic [7:0]             tx_data;
    logic                   tx_go;
    logic                   tx_done;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        ack;
    logic                   busy;

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(.NREQ(NREQ), .MAXB(MAXB)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_len  (req_len),
        .tx_data  (tx_data),
        .tx_go    (tx_go),
        .tx_done  (tx_done),
        .grant    (grant),
        .ack      (ack),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level reference: a frame is a byte list; each byte is a go then a wait for done.
    int              cyc = 0;
    int              m_ptr;
    bit              m_active, m_go, m_wait, m_ack_due, m_first;
    int              m_owner;
    logic [7:0]      m_q[$];
    logic [7:0]      m_cur, m_last;
    int              m_start_cyc;
    int              prev_done_cyc;
    int              w, n, c;
    logic [NREQ-1:0] exp_grant;

    logic [7:0]      go_log[$];
    int              ack_log[$];
    int              lat_log[$];
    int              ta_log[$];

    always @(negedge sys_clk) begin
        cyc++;
        if (!rst_n) begin
            m_ptr = NREQ - 1;
            m_active = 0; m_go = 0; m_wait = 0; m_ack_due = 0; m_first = 0;
            m_owner = 0; m_q.delete(); m_cur = 0; m_last = 0;
            prev_done_cyc = -1;
        end else begin
            exp_grant = m_active ? (NREQ'(1) << m_owner) : '0;
            chk("busy", busy, m_active);
            chk("grant", grant, exp_grant);
            chk("grant_onehot", $onehot0(grant), 1);
            chk("tx_go", tx_go, m_go);
            chk("ack", ack, m_ack_due ? exp_grant : '0);
            chk("tx_data", tx_data, m_go ? m_cur : (m_active ? m_last : 8'h00));

            if (tx_go === 1'b1) begin
                go_log.push_back(tx_data);
                if (m_first) begin
                    lat_log.push_back(cyc - m_start_cyc + 1);
                    if (prev_done_cyc >= 0) ta_log.push_back(cyc - prev_done_cyc + 1);
                end
            end
            for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) ack_log.push_back(i);

            if (!m_active) begin
                if (req != '0) begin
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (w < 0 && req[c]) w = c;
                    end
                    m_q.delete();
`ifdef UART_ARB_HDR_EN
                    m_q.push_back(8'hA0 | 8'(w));
`endif
                    n = int'(req_len[w*3 +: 3]);
                    if (n > MAXB) n = MAXB;
                    for (int j = 0; j < n; j++) m_q.push_back(req_data[(w*MAXB + j)*8 +: 8]);
                    m_active = 1; m_owner = w; m_last = 0; m_first = 1; m_start_cyc = cyc;
                    if (m_q.size() == 0) m_ack_due = 1;
                    else begin m_cur = m_q.pop_front(); m_go = 1; end
                end
            end else if (m_go) begin
                m_last = m_cur; m_go = 0; m_first = 0; m_wait = 1;
            end else if (m_wait) begin
                if (tx_done) begin
                    prev_done_cyc = cyc;
                    m_wait = 0;
                    if (m_q.size() == 0) m_ack_due = 1;
                    else begin m_cur = m_q.pop_front(); m_go = 1; end
                end
            end else begin
                m_ack_due = 0; m_active = 0; m_ptr = m_owner;
            end
        end
    end

    // Byte transmitter stand-in: tx_done a fixed or random number of cycles after tx_go.
    int done_dly = 10;
    bit rand_dly = 0;
    bit spur_en  = 0;
    int done_cnt;
    initial begin
        tx_done  = 1'b0;
        done_cnt = 0;
        forever begin
            @(negedge sys_clk);
            if (tx_go === 1'b1) done_cnt = rand_dly ? int'($urandom_range(12, 1)) : done_dly;
            @(posedge sys_clk);
            #1;
            tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end else if (spur_en && $urandom_range(7) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input int len, input logic [DW-1:0] data);
        req_len[i*3 +: 3]   = 3'(len);
        req_data[i*DW +: DW] = data;
        req[i] = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (ack_log.size() < target && k < budget) begin @(posedge sys_clk); k++; end
        #1;
        chk(nm, ack_log.size() >= target, 1);
    endtask

    task automatic wait_go(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (go_log.size() < target && k < budget) begin @(posedge sys_clk); k++; end
        #1;
        chk(nm, go_log.size() >= target, 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin @(posedge sys_clk); #1; k++; end
        chk(nm, busy, 0);
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    int              b_go, b_ack, b_lat, b_ta;
    int              hdr;
    logic [NREQ-1:0] acked;
    logic [7:0]      exp_b[$];

    initial begin
`ifdef UART_ARB_HDR_EN
        hdr = 1;
`else
        hdr = 0;
`endif
        rst_n = 1'b0; req = '0; req_data = '0; req_len = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_go", tx_go, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        @(posedge sys_clk); #2;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // three-byte frame from requester 0
        b_go = go_log.size(); b_ack = ack_log.size(); b_lat = lat_log.size();
        done_dly = 10;
        set_req(0, 3, 40'h00_0033_2211);
        wait_go(b_go + 1, 50, "s1_first_go_timeout");
        chk("s1_grant", grant, 4'b0001);
        wait_acks(b_ack + 1, 300, "s1_ack_timeout");
        req = '0;
        wait_idle(20, "s1_idle");
        exp_b.delete();
        if (hdr != 0) exp_b.push_back(8'hA0);
        exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
        chk("s1_go_count", go_log.size() - b_go, exp_b.size());
        for (int j = 0; j < exp_b.size(); j++) chk("s1_byte", go_log[b_go + j], exp_b[j]);
        chk("s1_ack_count", ack_log.size() - b_ack, 1);
        chk("s1_ack_owner", ack_log[b_ack], 0);
        chk("s1_latency", lat_log[b_lat], 2);

        // all four requesting, one byte each, from reset
        do_reset();
        done_dly = 3;
        b_ack = ack_log.size(); b_ta = ta_log.size();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, DW'(8'h40 + i));
        wait_acks(b_ack + 5, 500, "s2_ack_timeout");
        req = '0;
        wait_idle(50, "s2_idle");
        for (int j = 0; j < 5; j++) chk("s2_order", ack_log[b_ack + j], j % NREQ);
        chk("s2_turnaround", ta_log[b_ta], 4);

        // over-long and zero-length frames
        b_go = go_log.size(); b_ack = ack_log.size();
        set_req(1, 7, 40'h55_4433_2211);
        wait_acks(b_ack + 1, 300, "s3_long_ack_timeout");
        req = '0;
        wait_idle(20, "s3_idle_a");
        chk("s3_clamped_go_count", go_log.size() - b_go, MAXB + hdr);
        b_go = go_log.size(); b_ack = ack_log.size();
        set_req(2, 0, 40'h00_0000_00EE);
        wait_acks(b_ack + 1, 100, "s3_zero_ack_timeout");
        req = '0;
        wait_idle(20, "s3_idle_b");
        chk("s3_zero_go_count", go_log.size() - b_go, hdr);
        chk("s3_zero_ack_owner", ack_log[b_ack], 2);

        // inputs change mid-frame; spurious tx_done while idle
        done_dly = 10;
        b_go = go_log.size(); b_ack = ack_log.size();
        set_req(3, 4, 40'h00_D4C3_B2A1);
        wait_go(b_go + 1, 50, "s4_go_timeout");
        req_data[3*DW +: DW] = 40'hFF_FFFF_FFFF;
        req_len[3*3 +: 3] = 3'd0;
        req[3] = 1'b0;
        wait_acks(b_ack + 1, 300, "s4_ack_timeout");
        wait_idle(20, "s4_idle");
        exp_b.delete();
        if (hdr != 0) exp_b.push_back(8'hA3);
        exp_b.push_back(8'hA1); exp_b.push_back(8'hB2); exp_b.push_back(8'hC3); exp_b.push_back(8'hD4);
        chk("s4_go_count", go_log.size() - b_go, exp_b.size());
        for (int j = 0; j < exp_b.size(); j++) chk("s4_latched_byte", go_log[b_go + j], exp_b[j]);
        b_go = go_log.size();
        spur_en = 1;
        repeat (30) begin @(negedge sys_clk); chk("s4_spurious_idle", busy, 0); end
        spur_en = 0;
        chk("s4_spurious_go", go_log.size() - b_go, 0);

        // reset in the middle of a five-byte frame
        @(posedge sys_clk); #1;
        b_go = go_log.size(); b_ack = ack_log.size();
        set_req(0, 5, 40'h55_4433_2211);
        wait_go(b_go + 2, 100, "s5_go_timeout");
        @(posedge sys_clk); #2;
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("s5_rst_tx_data", tx_data, 0);
        chk("s5_rst_tx_go", tx_go, 0);
        chk("s5_rst_grant", grant, 0);
        chk("s5_rst_ack", ack, 0);
        chk("s5_rst_busy", busy, 0);
        repeat (2) @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        repeat (20) begin @(negedge sys_clk); chk("s5_stays_idle", busy, 0); end
        chk("s5_no_ack", ack_log.size() - b_ack, 0);

`ifdef UART_ARB_HDR_EN
        // header byte ahead of payload
        @(posedge sys_clk); #1;
        b_go = go_log.size(); b_ack = ack_log.size();
        set_req(2, 2, 40'h00_0000_C35A);
        wait_acks(b_ack + 1, 300, "s6_ack_timeout");
        req = '0;
        wait_idle(20, "s6_idle");
        chk("s6_go_count", go_log.size() - b_go, 3);
        chk("s6_hdr", go_log[b_go], 8'hA2);
        chk("s6_b0", go_log[b_go + 1], 8'h5A);
        chk("s6_b1", go_log[b_go + 2], 8'hC3);
        chk("s6_ack_owner", ack_log[b_ack], 2);
`endif

        // random traffic
        rand_dly = 1;
        spur_en  = 1;
        b_ack = ack_log.size();
        repeat (3000) begin
            @(negedge sys_clk);
            acked = ack;
            @(posedge sys_clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(5) == 0)
                        set_req(i, int'($urandom_range(7)), DW'({$urandom, $urandom}));
                end else if (acked[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                    else set_req(i, int'($urandom_range(7)), DW'({$urandom, $urandom}));
                end else if ($urandom_range(7) == 0) begin
                    req_data[i*DW +: DW] = DW'({$urandom, $urandom});
                end
            end
        end
        req = '0;
        spur_en = 0;
        wait_idle(200, "rand_idle");
        chk("rand_ack_activity", ack_log.size() - b_ack > 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
